// File: rtl/serdesphy_rx_framer.sv
// serdesphy_rx_framer
//   Sync-word RX framer. Hunts for SYNC_PATTERN at any bit offset in the
//   recovered serial stream. It qualifies lock over LOCK_CNT consecutive frames
//   and drops lock after UNLOCK_CNT consecutive bad sync slots. While locked it
//   emits aligned WORD_W-bit payload words over a valid/ready handshake.
//
//   Optional feature (macro RX_POLARITY_AUTO_EN):
//     - When defined, SEARCH also accepts ~SYNC_PATTERN.
//     - On such a match the rest of the stream is inverted before use, until
//       SEARCH is re-entered.
//     - When undefined, only SYNC_PATTERN matches and rx_polarity_inv is tied 0.
//
// Ports
//   clk_24m, rst_24m            clock, synchronous active-high reset
//   rx_en, rx_align_rst         enable, restart search / clear stickies
//   bit_data/valid/error        serial bit input from the deserializer
//   word_data/valid/ready/err   payload word handshake (first bit = MSB)
//   frame_start                 word is payload word 0 of its frame
//   rx_aligned, rx_align_state  lock flag, state (00 SEARCH 01 VERIFY 10 LOCKED 11 IDLE)
//   rx_overflow                 sticky: word dropped under backpressure
//   lock_loss_cnt               saturating LOCKED->SEARCH count
//   rx_polarity_inv             stream treated as inverted
module serdesphy_rx_framer #(
  parameter int unsigned       WORD_W       = 16,
  parameter logic [WORD_W-1:0] SYNC_PATTERN = 16'hF0A5,
  parameter int unsigned       FRAME_WORDS  = 4,
  parameter int unsigned       LOCK_CNT     = 3,
  parameter int unsigned       UNLOCK_CNT   = 2
) (
  input  logic              clk_24m,
  input  logic              rst_24m,
  input  logic              rx_en,
  input  logic              rx_align_rst,
  input  logic              bit_data,
  input  logic              bit_valid,
  input  logic              bit_error,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_err,
  output logic              frame_start,
  output logic              rx_aligned,
  output logic [1:0]        rx_align_state,
  output logic              rx_overflow,
  output logic [7:0]        lock_loss_cnt,
  output logic              rx_polarity_inv
);

  localparam logic [1:0] StSearch = 2'b00;
  localparam logic [1:0] StVerify = 2'b01;
  localparam logic [1:0] StLocked = 2'b10;
  localparam logic [1:0] StIdle   = 2'b11;

  localparam int unsigned BCW = $clog2(WORD_W);
  localparam int unsigned WIW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned FCW = $clog2(WORD_W + 1);
  localparam int unsigned HCW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MCW = $clog2(UNLOCK_CNT + 1);

  localparam logic [BCW-1:0] BitLast  = BCW'(WORD_W - 1);
  localparam logic [WIW-1:0] SyncIdx  = WIW'(FRAME_WORDS);
  localparam logic [FCW-1:0] FillFull = FCW'(WORD_W);
  localparam logic [FCW-1:0] FillLast = FCW'(WORD_W - 1);
  localparam logic [HCW-1:0] HitsLock = HCW'(LOCK_CNT);
  localparam logic [MCW-1:0] MissDrop = MCW'(UNLOCK_CNT);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] window_q, window_d;
  logic [FCW-1:0]    fill_q, fill_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIW-1:0]    word_idx_q, word_idx_d;
  logic [HCW-1:0]    hits_q, hits_d;
  logic [MCW-1:0]    miss_q, miss_d;
  logic              err_acc_q, err_acc_d;
  logic              pol_q, pol_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              word_err_q, word_err_d;
  logic              frame_start_q, frame_start_d;
  logic              word_valid_q, word_valid_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        lock_loss_q, lock_loss_d;

  logic              bit_in;
  logic [WORD_W-1:0] win_next;
  logic              sync_hit, sync_hit_inv;
  logic              word_end, sync_slot, err_now, to_search;
  logic [BCW-1:0]    bit_cnt_adv;
  logic [WIW-1:0]    word_idx_adv;

  assign bit_in   = bit_data ^ pol_q;
  assign win_next = {window_q[WORD_W-2:0], bit_in};
  assign sync_hit = (win_next == SYNC_PATTERN);

`ifdef RX_POLARITY_AUTO_EN
  assign sync_hit_inv    = (win_next == ~SYNC_PATTERN);
  assign rx_polarity_inv = pol_q;
`else
  assign sync_hit_inv    = 1'b0;
  assign rx_polarity_inv = 1'b0;
`endif

  // Frame position is tracked as (word index, bit in word); index FRAME_WORDS
  // is the sync slot, so the pair wraps after (FRAME_WORDS+1)*WORD_W bits.
  assign word_end     = (bit_cnt_q == BitLast);
  assign sync_slot    = (word_idx_q == SyncIdx);
  assign bit_cnt_adv  = word_end ? '0 : bit_cnt_q + 1'b1;
  assign word_idx_adv = !word_end ? word_idx_q : (sync_slot ? '0 : word_idx_q + 1'b1);
  assign err_now      = err_acc_q | bit_error;

  always_comb begin
    state_d       = state_q;
    window_d      = window_q;
    fill_d        = fill_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    hits_d        = hits_q;
    miss_d        = miss_q;
    err_acc_d     = err_acc_q;
    pol_d         = pol_q;
    word_data_d   = word_data_q;
    word_err_d    = word_err_q;
    frame_start_d = frame_start_q;
    word_valid_d  = word_valid_q;
    overflow_d    = overflow_q;
    lock_loss_d   = lock_loss_q;
    to_search     = 1'b0;

    if (word_valid_q && word_ready) word_valid_d = 1'b0;

    if (!rx_en) begin
      state_d      = StIdle;
      word_valid_d = 1'b0;
      fill_d       = '0;
      bit_cnt_d    = '0;
      word_idx_d   = '0;
      hits_d       = '0;
      miss_d       = '0;
      err_acc_d    = 1'b0;
      pol_d        = 1'b0;
    end else if (rx_align_rst) begin
      to_search    = 1'b1;
      window_d     = '0;
      overflow_d   = 1'b0;
      word_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: to_search = 1'b1;

        StSearch: begin
          if (bit_valid) begin
            window_d = win_next;
            if (bit_error) begin
              fill_d = '0;
            end else begin
              if (fill_q != FillFull) fill_d = fill_q + 1'b1;
              // Window is full once this bit lands on the WORD_W-th position.
              if ((fill_q >= FillLast) && (sync_hit || sync_hit_inv)) begin
                state_d    = (LOCK_CNT == 1) ? StLocked : StVerify;
                hits_d     = HCW'(1);
                miss_d     = '0;
                bit_cnt_d  = '0;
                word_idx_d = '0;
                err_acc_d  = 1'b0;
                pol_d      = sync_hit_inv && !sync_hit;
              end
            end
          end
        end

        StVerify: begin
          if (bit_valid) begin
            window_d   = win_next;
            bit_cnt_d  = bit_cnt_adv;
            word_idx_d = word_idx_adv;
            if (bit_error) begin
              to_search = 1'b1;
            end else if (word_end && sync_slot) begin
              if (!sync_hit) begin
                to_search = 1'b1;
              end else begin
                hits_d = hits_q + 1'b1;
                if ((hits_q + 1'b1) == HitsLock) begin
                  state_d = StLocked;
                  miss_d  = '0;
                end
              end
            end
          end
        end

        StLocked: begin
          if (bit_valid) begin
            window_d   = win_next;
            bit_cnt_d  = bit_cnt_adv;
            word_idx_d = word_idx_adv;
            if (!word_end) begin
              err_acc_d = err_now;
            end else begin
              err_acc_d = 1'b0;
              if (sync_slot) begin
                // A flagged bit anywhere in the sync slot makes it a miss.
                if (sync_hit && !err_now) begin
                  miss_d = '0;
                end else if ((miss_q + 1'b1) == MissDrop) begin
                  to_search = 1'b1;
                  if (lock_loss_q != 8'hFF) lock_loss_d = lock_loss_q + 8'd1;
                end else begin
                  miss_d = miss_q + 1'b1;
                end
              end else if (word_valid_q && !word_ready) begin
                // Held word wins; the new one is lost.
                overflow_d = 1'b1;
              end else begin
                word_data_d   = win_next;
                word_err_d    = err_now;
                frame_start_d = (word_idx_q == '0);
                word_valid_d  = 1'b1;
              end
            end
          end
        end

        default: to_search = 1'b1;
      endcase
    end

    // Every SEARCH entry restarts the hunt and re-evaluates polarity.
    if (to_search) begin
      state_d    = StSearch;
      fill_d     = '0;
      bit_cnt_d  = '0;
      word_idx_d = '0;
      hits_d     = '0;
      miss_d     = '0;
      err_acc_d  = 1'b0;
      pol_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_24m) begin
    if (rst_24m) begin
      state_q       <= StIdle;
      window_q      <= '0;
      fill_q        <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      hits_q        <= '0;
      miss_q        <= '0;
      err_acc_q     <= 1'b0;
      pol_q         <= 1'b0;
      word_data_q   <= '0;
      word_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      word_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      lock_loss_q   <= '0;
    end else begin
      state_q       <= state_d;
      window_q      <= window_d;
      fill_q        <= fill_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      hits_q        <= hits_d;
      miss_q        <= miss_d;
      err_acc_q     <= err_acc_d;
      pol_q         <= pol_d;
      word_data_q   <= word_data_d;
      word_err_q    <= word_err_d;
      frame_start_q <= frame_start_d;
      word_valid_q  <= word_valid_d;
      overflow_q    <= overflow_d;
      lock_loss_q   <= lock_loss_d;
    end
  end

  assign word_data      = word_data_q;
  assign word_valid     = word_valid_q;
  assign word_err       = word_err_q;
  assign frame_start    = frame_start_q;
  assign rx_aligned     = (state_q == StLocked);
  assign rx_align_state = state_q;
  assign rx_overflow    = overflow_q;
  assign lock_loss_cnt  = lock_loss_q;

endmodule

// File: tb/tb_serdesphy_rx_framer.sv
module tb_serdesphy_rx_framer;

  localparam logic [15:0] SYNC = 16'hF0A5;

  logic        clk_24m = 1'b0;
  logic        rst_24m = 1'b1;
  logic        rx_en = 1'b0;
  logic        rx_align_rst = 1'b0;
  logic        bit_data = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_error = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        word_err;
  logic        frame_start;
  logic        rx_aligned;
  logic [1:0]  rx_align_state;
  logic        rx_overflow;
  logic [7:0]  lock_loss_cnt;
  logic        rx_polarity_inv;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] pay [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [17:0] wq [$];

  always #5 clk_24m = ~clk_24m;

  serdesphy_rx_framer dut (
    .clk_24m        (clk_24m),
    .rst_24m        (rst_24m),
    .rx_en          (rx_en),
    .rx_align_rst   (rx_align_rst),
    .bit_data       (bit_data),
    .bit_valid      (bit_valid),
    .bit_error      (bit_error),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_err       (word_err),
    .frame_start    (frame_start),
    .rx_aligned     (rx_aligned),
    .rx_align_state (rx_align_state),
    .rx_overflow    (rx_overflow),
    .lock_loss_cnt  (lock_loss_cnt),
    .rx_polarity_inv(rx_polarity_inv)
  );

  // Record every accepted word as {err, frame_start, data}.
  always @(negedge clk_24m) begin
    if (!rst_24m && word_valid && word_ready) wq.push_back({word_err, frame_start, word_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    return 18'bx;
  endfunction

  function automatic logic [17:0] exp_word(input int i, input logic err);
    return {err, (i == 0), pay[i]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_24m);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic e);
    bit_data  = b;
    bit_error = e;
    bit_valid = 1'b1;
    @(posedge clk_24m);
    #1;
    bit_valid = 1'b0;
    bit_error = 1'b0;
  endtask

  // err_pos: transmission index (0 = first bit) to flag, -1 for none.
  task automatic send_word(input logic [15:0] w, input int err_pos);
    for (int i = 0; i < 16; i++) send_bit(w[15-i], (i == err_pos));
  endtask

  task automatic send_payloads(input logic inv);
    for (int i = 0; i < 4; i++) send_word(pay[i] ^ {16{inv}}, -1);
  endtask

  task automatic send_frame(input logic [15:0] sync_w, input logic inv);
    send_word(sync_w ^ {16{inv}}, -1);
    send_payloads(inv);
  endtask

  task automatic pulse_align_rst();
    rx_align_rst = 1'b1;
    @(posedge clk_24m);
    #1;
    rx_align_rst = 1'b0;
  endtask

  logic       exp_pol;
  logic       exp_aligned;
  int         exp_n;

  initial begin
    // Reset state
    idle(3);
    check("rst_state", rx_align_state, 2'b11);
    check("rst_aligned", rx_aligned, 1'b0);
    check("rst_valid", word_valid, 1'b0);
    check("rst_overflow", rx_overflow, 1'b0);
    check("rst_lossc", lock_loss_cnt, 8'd0);

    rst_24m = 1'b0;
    rx_en   = 1'b1;
    idle(1);
    check("idle_to_search", rx_align_state, 2'b00);

    // Acquisition: 3 junk bits then three frames
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_word(SYNC, -1);
    check("acq_verify", rx_align_state, 2'b01);
    send_payloads(1'b0);
    send_frame(SYNC, 1'b0);
    check("acq_still_verify", rx_align_state, 2'b01);
    send_word(SYNC, -1);
    check("acq_locked", rx_align_state, 2'b10);
    check("acq_aligned", rx_aligned, 1'b1);
    check("acq_no_words", wq.size(), 0);
    send_payloads(1'b0);
    idle(2);
    check("acq_nwords", wq.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("acq_w%0d", i), wq_at(i), exp_word(i, 1'b0));

    // Backpressure: 1234 held, 5678 dropped
    wq.delete();
    word_ready = 1'b0;
    send_word(SYNC, -1);
    send_word(pay[0], -1);
    send_word(pay[1], -1);
    check("bp_overflow", rx_overflow, 1'b1);
    check("bp_valid", word_valid, 1'b1);
    check("bp_held", word_data, 16'h1234);
    check("bp_fstart", frame_start, 1'b1);
    word_ready = 1'b1;
    send_word(pay[2], -1);
    send_word(pay[3], -1);
    idle(2);
    check("bp_nwords", wq.size(), 3);
    check("bp_w0", wq_at(0), exp_word(0, 1'b0));
    check("bp_w1", wq_at(1), exp_word(2, 1'b0));
    check("bp_w2", wq_at(2), exp_word(3, 1'b0));

    // Bit error inside payload word 0
    wq.delete();
    send_word(SYNC, -1);
    send_word(pay[0], 5);
    send_word(pay[1], -1);
    send_word(pay[2], -1);
    send_word(pay[3], -1);
    idle(2);
    check("err_nwords", wq.size(), 4);
    check("err_w0", wq_at(0), exp_word(0, 1'b1));
    check("err_w1", wq_at(1), exp_word(1, 1'b0));

    // One corrupt sync keeps lock, two consecutive drop it
    send_word(16'h0000, -1);
    check("miss1_locked", rx_align_state, 2'b10);
    check("miss1_lossc", lock_loss_cnt, 8'd0);
    send_payloads(1'b0);
    send_frame(SYNC, 1'b0);
    send_word(16'h0000, -1);
    send_payloads(1'b0);
    send_word(16'h0000, -1);
    check("miss2_state", rx_align_state, 2'b00);
    check("miss2_aligned", rx_aligned, 1'b0);
    check("miss2_lossc", lock_loss_cnt, 8'd1);

    // Align restart, then a bit error while verifying
    pulse_align_rst();
    check("arst_state", rx_align_state, 2'b00);
    check("arst_overflow", rx_overflow, 1'b0);
    check("arst_valid", word_valid, 1'b0);
    send_word(SYNC, -1);
    check("verr_verify", rx_align_state, 2'b01);
    send_word(pay[0], 5);
    check("verr_search", rx_align_state, 2'b00);

    // Inverted stream
    pulse_align_rst();
    idle(2);
    wq.delete();
    send_frame(SYNC, 1'b1);
    send_frame(SYNC, 1'b1);
    send_frame(SYNC, 1'b1);
    idle(2);
`ifdef RX_POLARITY_AUTO_EN
    exp_pol     = 1'b1;
    exp_aligned = 1'b1;
    exp_n       = 4;
`else
    exp_pol     = 1'b0;
    exp_aligned = 1'b0;
    exp_n       = 0;
`endif
    check("inv_pol", rx_polarity_inv, exp_pol);
    check("inv_aligned", rx_aligned, exp_aligned);
    check("inv_nwords", wq.size(), exp_n);
    for (int i = 0; i < exp_n; i++) check($sformatf("inv_w%0d", i), wq_at(i), exp_word(i, 1'b0));

    // Reset for two cycles mid-stream
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    rst_24m = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("mrst_state", rx_align_state, 2'b11);
    check("mrst_aligned", rx_aligned, 1'b0);
    check("mrst_data", word_data, 16'h0000);
    check("mrst_valid", word_valid, 1'b0);
    check("mrst_err", word_err, 1'b0);
    check("mrst_fstart", frame_start, 1'b0);
    check("mrst_overflow", rx_overflow, 1'b0);
    check("mrst_lossc", lock_loss_cnt, 8'd0);
    check("mrst_pol", rx_polarity_inv, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
